// File: rtl/afifo_rd_stream_pkg.sv
// Shared types for the async-FIFO read-side drain stage.
package afifo_rd_stream_pkg;

    // Skid buffer operation, encoded as {push, pop}.
    typedef enum logic [1:0] {
        SKID_HOLD = 2'b00,
        SKID_POP  = 2'b01,
        SKID_PUSH = 2'b10,
        SKID_BOTH = 2'b11
    } skid_op_e;

endpackage

// File: rtl/afifo_skid_buf.sv
// Circular skid buffer holding words captured from the FIFO; head entry feeds the stream.
module afifo_skid_buf
    import afifo_rd_stream_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SKID_DEPTH = 3,
    parameter int OCC_W      = $clog2(SKID_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic [OCC_W-1:0] o_occ
);

    localparam int PTR_W = $clog2(SKID_DEPTH);

    logic [WIDTH-1:0] r_mem [SKID_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [OCC_W-1:0] r_occ;
    skid_op_e         w_op;

    // Explicit wrap so non-power-of-2 depths never index past the array.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_op = skid_op_e'({i_push, i_pop && (r_occ != '0)});

    // NOTE: the array is reset too, so m_data reads zero out of reset rather than X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            // NOTE: non-blocking updates let push and pop read the same pre-edge pointers.
            case (w_op)
                SKID_PUSH: begin
                    r_mem[r_tail] <= i_data;
                    r_tail        <= next_ptr(r_tail);
                    r_occ         <= r_occ + 1'b1;
                end
                SKID_POP: begin
                    r_head <= next_ptr(r_head);
                    r_occ  <= r_occ - 1'b1;
                end
                SKID_BOTH: begin
                    r_mem[r_tail] <= i_data;
                    r_tail        <= next_ptr(r_tail);
                    r_head        <= next_ptr(r_head);
                end
                default: ;
            endcase
        end
    end

    assign o_head = r_mem[r_head];
    assign o_occ  = r_occ;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(!i_flush && w_op == SKID_PUSH && r_occ == OCC_W'(SKID_DEPTH)));

endmodule

// File: rtl/afifo_rd_stream.sv
// Read-domain drain stage: credit-gated rinc, in-flight tracking, skid capture and a valid/ready stream.
module afifo_rd_stream
    import afifo_rd_stream_pkg::*;
#(
    parameter int  WIDTH      = 8,
    parameter int  SKID_DEPTH = 3,
    parameter int  CNT_W      = 16,
    localparam int OCC_W      = $clog2(SKID_DEPTH + 1)
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rempty,
    input  logic [WIDTH-1:0] rdata,
    output logic             rinc,
    input  logic             flush,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [OCC_W-1:0] buf_occ,
    output logic [CNT_W-1:0] xfer_cnt
);

    logic             r_inflight;
    logic [CNT_W-1:0] r_xfer_cnt;
    logic             w_credit_ok;
    logic             w_fire;
    logic             w_push;
    logic             w_pop;

    // Credit counts the word already requested, so m_ready never reaches rinc.
    assign w_credit_ok = (int'(buf_occ) + int'(r_inflight)) < SKID_DEPTH;
    assign rinc        = ~rrst & ~rempty & ~flush & w_credit_ok;
    assign w_fire      = rinc & ~rempty;
    assign w_push      = r_inflight & ~flush;
    assign w_pop       = m_valid & m_ready;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_inflight <= 1'b0;
            r_xfer_cnt <= '0;
        end else begin
            r_inflight <= w_fire;
            if (w_pop) begin
                r_xfer_cnt <= r_xfer_cnt + 1'b1;
            end
        end
    end

    afifo_skid_buf #(
        .WIDTH     (WIDTH),
        .SKID_DEPTH(SKID_DEPTH),
        .OCC_W     (OCC_W)
    ) u_skid (
        .clk    (rclk),
        .rst    (rrst),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_flush(flush),
        .i_data (rdata),
        .o_head (m_data),
        .o_occ  (buf_occ)
    );

    assign m_valid  = (buf_occ != '0);
    assign xfer_cnt = r_xfer_cnt;

endmodule

// File: tb/tb_afifo_rd_stream.sv
// Directed and randomised checks of afifo_rd_stream against a small FIFO model.
module tb_afifo_rd_stream;

    logic       rclk;
    logic       rrst;
    logic       rempty;
    logic [7:0] rdata;
    logic       flush;
    logic       m_ready;
    logic       hold_empty;

    logic       rinc,    rinc_w;
    logic       m_valid, m_valid_w;
    logic [7:0] m_data,  m_data_w;
    logic [1:0] buf_occ, buf_occ_w;
    logic [15:0] xfer_cnt;
    logic [3:0]  xfer_cnt_w;

    logic [7:0] fifo_mem [1024];
    int wr_ptr = 0;
    int rd_ptr;

    int n_cmp = 0;
    int n_err = 0;

    afifo_rd_stream dut (
        .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
        .flush(flush), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .buf_occ(buf_occ), .xfer_cnt(xfer_cnt)
    );

    afifo_rd_stream #(.CNT_W(4)) dut_w (
        .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc_w),
        .flush(flush), .m_valid(m_valid_w), .m_ready(m_ready), .m_data(m_data_w),
        .buf_occ(buf_occ_w), .xfer_cnt(xfer_cnt_w)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // FIFO read side: registered rdata, one cycle after an accepted read.
    assign rempty = hold_empty | (wr_ptr == rd_ptr);
    always @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rd_ptr <= 0;
            rdata  <= '0;
        end else if (rinc && !rempty) begin
            rdata  <= fifo_mem[rd_ptr & 1023];
            rd_ptr <= rd_ptr + 1;
        end
    end

    typedef struct {
        int         n_load;
        logic [7:0] ld_base;
        logic [7:0] ld_step;
        logic       rdy;
        logic       fl;
        logic       e_rinc;
        logic       e_valid;
        logic [7:0] e_data;
        int         e_occ;
        int         e_cnt;
    } step_t;

    step_t vec [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_word(input logic [7:0] w);
        fifo_mem[wr_ptr & 1023] = w;
        wr_ptr++;
    endtask

    task automatic do_reset();
        @(negedge rclk);
        rrst = 1'b1; flush = 1'b0; m_ready = 1'b0; hold_empty = 1'b0; wr_ptr = 0;
        #1;
        check("rst_rinc", rinc, 0);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_occ", buf_occ, 0);
        check("rst_cnt", xfer_cnt, 0);
        @(negedge rclk);
        rrst = 1'b0;
    endtask

    initial begin
        int run, best, ones, exp_w, got, d;

        rrst = 1'b1; flush = 1'b0; m_ready = 1'b0; hold_empty = 1'b0;

        // Reset, then idle with the FIFO empty.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge rclk); #1;
            check("idle_rinc", rinc, 0);
            check("idle_valid", m_valid, 0);
            check("idle_occ", buf_occ, 0);
            check("idle_cnt", xfer_cnt, 0);
        end

        // Single word latency, then flush with occ=2 and a word in flight (pop in flush cycle counts).
        vec[0]  = '{1, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 0};
        vec[1]  = '{0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0};
        vec[2]  = '{0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1, 0};
        vec[3]  = '{0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1};
        vec[4]  = '{4, 8'h11, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1};
        vec[5]  = '{0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1};
        vec[6]  = '{0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1, 1};
        vec[7]  = '{0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 2, 1};
        vec[8]  = '{0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 2};
        vec[9]  = '{0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 2};
        vec[10] = '{0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h44, 1, 2};
        vec[11] = '{0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 3};
        for (int i = 0; i < 12; i++) begin
            @(negedge rclk);
            for (int k = 0; k < vec[i].n_load; k++) load_word(8'(vec[i].ld_base + k * vec[i].ld_step));
            m_ready = vec[i].rdy;
            flush   = vec[i].fl;
            #1;
            check($sformatf("vec%0d_rinc", i), rinc, vec[i].e_rinc);
            check($sformatf("vec%0d_valid", i), m_valid, vec[i].e_valid);
            if (vec[i].e_valid) check($sformatf("vec%0d_data", i), m_data, vec[i].e_data);
            check($sformatf("vec%0d_occ", i), buf_occ, vec[i].e_occ);
            check($sformatf("vec%0d_cnt", i), xfer_cnt, vec[i].e_cnt);
        end
        flush = 1'b0;

        // Ten words at full rate.
        do_reset();
        @(negedge rclk);
        m_ready = 1'b1;
        for (int k = 1; k <= 10; k++) load_word(8'(k));
        run = 0; best = 0; ones = 0; exp_w = 1;
        for (int c = 0; c < 30; c++) begin
            if (c != 0) @(negedge rclk);
            #1;
            if (rinc) begin run++; ones++; if (run > best) best = run; end else run = 0;
            if (m_valid) begin
                check("burst_data", m_data, exp_w);
                exp_w++;
            end
        end
        check("burst_rinc_run", best, 10);
        check("burst_rinc_total", ones, 10);
        check("burst_words", exp_w - 1, 10);
        check("burst_cnt", xfer_cnt, 10);

        // Ten words under back-pressure, then release.
        do_reset();
        @(negedge rclk);
        m_ready = 1'b0;
        for (int k = 1; k <= 10; k++) load_word(8'(k));
        ones = 0;
        for (int c = 0; c < 8; c++) begin
            if (c != 0) @(negedge rclk);
            #1;
            if (rinc) ones++;
            if (m_valid) check("bp_hold_data", m_data, 8'h01);
        end
        check("bp_fires", ones, 3);
        check("bp_occ", buf_occ, 3);
        check("bp_rinc_off", rinc, 0);
        check("bp_valid", m_valid, 1);
        got = 0;
        for (int c = 0; c < 40 && got < 10; c++) begin
            @(negedge rclk);
            m_ready = 1'b1;
            #1;
            if (m_valid) begin
                got++;
                check("bp_data", m_data, got);
            end
        end
        @(negedge rclk); m_ready = 1'b0; #1;
        check("bp_words", got, 10);
        check("bp_cnt", xfer_cnt, 10);
        check("bp_occ_end", buf_occ, 0);

        // Counter wrap: 18 transfers on the 4-bit instance.
        do_reset();
        @(negedge rclk);
        m_ready = 1'b1;
        for (int k = 0; k < 18; k++) load_word(8'(k + 8'h40));
        for (int c = 0; c < 30; c++) @(negedge rclk);
        #1;
        check("wrap_cnt4", xfer_cnt_w, 2);
        check("wrap_cnt16", xfer_cnt, 18);

        // Random back-pressure and empty gaps, scored against FIFO order.
        do_reset();
        d = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge rclk);
            if ($urandom_range(1) == 0 && (wr_ptr - rd_ptr) < 64) load_word(8'($urandom));
            hold_empty = ($urandom_range(3) == 0);
            m_ready    = $urandom_range(1) != 0;
            #1;
            if (m_valid && m_ready) begin
                check("rand_data", m_data, fifo_mem[d & 1023]);
                d++;
            end
            check("rand_occ_le3", buf_occ <= 2'd3 && buf_occ_w == buf_occ, 1);
        end
        for (int c = 0; c < 200 && d != wr_ptr; c++) begin
            @(negedge rclk);
            hold_empty = 1'b0;
            m_ready    = 1'b1;
            #1;
            if (m_valid) begin
                check("drain_data", m_data, fifo_mem[d & 1023]);
                d++;
            end
        end
        @(negedge rclk); m_ready = 1'b0; #1;
        check("rand_drained", d, wr_ptr);
        check("rand_cnt16", xfer_cnt, 16'(d));
        check("rand_cnt4", xfer_cnt_w, 4'(d));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
